// File: rtl/mult_seq_pkg.sv
// mult_seq_pkg: shared definitions for the sequential multiplier slice.
//   - state_t   : FSM state encoding (IDLE, RUN, FIX)
//   - cnt_width : width of a slice counter for a given slice count
//   - DEF_*     : default operand and slice widths
package mult_seq_pkg;

  localparam int DEF_A_WIDTH = 32;
  localparam int DEF_B_WIDTH = 32;
  localparam int DEF_SLICE_A = 8;
  localparam int DEF_SLICE_B = 16;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2
  } state_t;

  // A counter over a single slice still needs one bit to exist.
  function automatic int cnt_width(input int slices);
    return (slices > 1) ? $clog2(slices) : 1;
  endfunction

endpackage

// File: rtl/mult_seq_if.sv
// mult_seq_if: start/busy/done handshake plus operand and product bus.
//   start, a, b        : requester -> multiplier
//   busy, done, product: multiplier -> requester
//   signed_mode        : requester -> multiplier, only when MULT_SEQ_SIGNED_EN
// Modports: master (requester side), slave (multiplier side).
interface mult_seq_if
  import mult_seq_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH
);

  logic                       start;
  logic [A_WIDTH-1:0]         a;
  logic [B_WIDTH-1:0]         b;
  logic                       busy;
  logic                       done;
  logic [A_WIDTH+B_WIDTH-1:0] product;

`ifdef MULT_SEQ_SIGNED_EN
  logic signed_mode;

  modport master (output start, a, b, signed_mode, input busy, done, product);
  modport slave  (input start, a, b, signed_mode, output busy, done, product);
`else
  modport master (output start, a, b, input busy, done, product);
  modport slave  (input start, a, b, output busy, done, product);
`endif

endinterface

// File: rtl/mult_slice.sv
// mult_slice: purely combinational SLICE_A x SLICE_B unsigned multiplier.
// Kept as its own module so it can be replaced by a DSP primitive.
//   x : SLICE_A-bit operand
//   y : SLICE_B-bit operand
//   p : SLICE_A+SLICE_B-bit full product
module mult_slice #(
  parameter int SLICE_A = 8,
  parameter int SLICE_B = 16
) (
  input  logic [SLICE_A-1:0]         x,
  input  logic [SLICE_B-1:0]         y,
  output logic [SLICE_A+SLICE_B-1:0] p
);

  localparam int SW = SLICE_A + SLICE_B;

  assign p = SW'(x) * SW'(y);

endmodule

// File: rtl/mult_seq.sv
// mult_seq: multi-cycle unsigned multiplier. One SLICE_A x SLICE_B partial
// product is accumulated per cycle; N = (A_WIDTH/SLICE_A)*(B_WIDTH/SLICE_B)
// cycles per product. A_WIDTH must be a multiple of SLICE_A and B_WIDTH a
// multiple of SLICE_B.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous active-high reset, wins over start
//   bus   : mult_seq_if.slave (start/a/b in, busy/done/product out)
// Optional feature: define MULT_SEQ_SIGNED_EN to add bus.signed_mode. Signed
// operands are reduced to magnitudes on capture and a FIX cycle negates the
// product when the signs differ; latency becomes N+1 for every operation.
module mult_seq
  import mult_seq_pkg::*;
#(
  parameter int A_WIDTH = DEF_A_WIDTH,
  parameter int B_WIDTH = DEF_B_WIDTH,
  parameter int SLICE_A = DEF_SLICE_A,
  parameter int SLICE_B = DEF_SLICE_B
) (
  input logic       clk,
  input logic       reset,
  mult_seq_if.slave bus
);

  localparam int NA = A_WIDTH / SLICE_A;
  localparam int NB = B_WIDTH / SLICE_B;
  localparam int IW = cnt_width(NA);
  localparam int JW = cnt_width(NB);
  localparam int PW = A_WIDTH + B_WIDTH;
  localparam int SW = SLICE_A + SLICE_B;
  localparam logic [IW-1:0] I_LAST = IW'(NA - 1);
  localparam logic [JW-1:0] J_LAST = JW'(NB - 1);

  state_t             state;
  logic [A_WIDTH-1:0] a_reg;
  logic [B_WIDTH-1:0] b_reg;
  logic [IW-1:0]      i_cnt;
  logic [JW-1:0]      j_cnt;
  logic [PW-1:0]      product_r;
  logic               busy_r;
  logic               done_r;

  logic [SLICE_A-1:0] a_slice;
  logic [SLICE_B-1:0] b_slice;
  logic [SW-1:0]      pp;
  logic [PW-1:0]      pp_shifted;
  logic               last_slice;
  logic [A_WIDTH-1:0] a_mag;
  logic [B_WIDTH-1:0] b_mag;

`ifdef MULT_SEQ_SIGNED_EN
  logic neg;

  // Two's complement negation of the most negative value yields the same bit
  // pattern, which is exactly its magnitude when read as unsigned.
  assign a_mag = (bus.signed_mode && bus.a[A_WIDTH-1]) ? -bus.a : bus.a;
  assign b_mag = (bus.signed_mode && bus.b[B_WIDTH-1]) ? -bus.b : bus.b;
`else
  assign a_mag = bus.a;
  assign b_mag = bus.b;
`endif

  // NOTE: every variable driven in always_comb gets a value on every path, so
  // no latch is inferred.
  always_comb begin
    a_slice    = SLICE_A'(a_reg >> (int'(i_cnt) * SLICE_A));
    b_slice    = SLICE_B'(b_reg >> (int'(j_cnt) * SLICE_B));
    pp_shifted = PW'(pp) << (int'(i_cnt) * SLICE_A + int'(j_cnt) * SLICE_B);
    last_slice = (i_cnt == I_LAST) && (j_cnt == J_LAST);
  end

  mult_slice #(
    .SLICE_A(SLICE_A),
    .SLICE_B(SLICE_B)
  ) u_slice (
    .x(a_slice),
    .y(b_slice),
    .p(pp)
  );

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples the values from before the edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      product_r <= '0;
      i_cnt     <= '0;
      j_cnt     <= '0;
      a_reg     <= '0;
      b_reg     <= '0;
`ifdef MULT_SEQ_SIGNED_EN
      neg       <= 1'b0;
`endif
    end else begin
      done_r <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            a_reg     <= a_mag;
            b_reg     <= b_mag;
`ifdef MULT_SEQ_SIGNED_EN
            neg       <= bus.signed_mode & (bus.a[A_WIDTH-1] ^ bus.b[B_WIDTH-1]);
`endif
            product_r <= '0;
            i_cnt     <= '0;
            j_cnt     <= '0;
            busy_r    <= 1'b1;
            state     <= RUN;
          end
        end
        RUN: begin
          product_r <= product_r + pp_shifted;
          if (last_slice) begin
            i_cnt <= '0;
            j_cnt <= '0;
`ifdef MULT_SEQ_SIGNED_EN
            state <= FIX;
`else
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b1;
`endif
          end else if (i_cnt == I_LAST) begin
            // a slices are the inner loop; wrap and step to the next b slice.
            i_cnt <= '0;
            j_cnt <= j_cnt + JW'(1);
          end else begin
            i_cnt <= i_cnt + IW'(1);
          end
        end
`ifdef MULT_SEQ_SIGNED_EN
        FIX: begin
          if (neg) product_r <= -product_r;
          state  <= IDLE;
          busy_r <= 1'b0;
          done_r <= 1'b1;
        end
`endif
        default: begin
          state  <= IDLE;
          busy_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy    = busy_r;
  assign bus.done    = done_r;
  assign bus.product = product_r;

endmodule

// File: tb/tb_mult_seq.sv
// tb_mult_seq: self-checking bench for mult_seq. Two instances: the default
// 32x32 (8x16 slices, N=8) and a 16x8 (4x8 slices, N=4) configuration.
// Follows MULT_SEQ_SIGNED_EN when it is defined for the build.
module tb_mult_seq;

`ifdef MULT_SEQ_SIGNED_EN
  localparam int LAT0 = 9;
  localparam int LAT1 = 5;
`else
  localparam int LAT0 = 8;
  localparam int LAT1 = 4;
`endif

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  mult_seq_if #(.A_WIDTH(32), .B_WIDTH(32)) if0 ();
  mult_seq_if #(.A_WIDTH(16), .B_WIDTH(8))  if1 ();

  mult_seq #(.A_WIDTH(32), .B_WIDTH(32), .SLICE_A(8), .SLICE_B(16)) u_dut0 (
    .clk  (clk),
    .reset(reset),
    .bus  (if0)
  );

  mult_seq #(.A_WIDTH(16), .B_WIDTH(8), .SLICE_A(4), .SLICE_B(8)) u_dut1 (
    .clk  (clk),
    .reset(reset),
    .bus  (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [63:0] exp;
    string       nm;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  task automatic launch0(input logic [31:0] av, input logic [31:0] bv, input logic sm);
    @(negedge clk);
    if0.start = 1'b1;
    if0.a     = av;
    if0.b     = bv;
`ifdef MULT_SEQ_SIGNED_EN
    if0.signed_mode = sm;
`else
    if (sm) $display("note: signed_mode ignored in unsigned build");
`endif
    @(negedge clk);
    if0.start = 1'b0;
  endtask

  // Counts busy cycles from the current negedge until done is seen.
  task automatic wait_done0(output int cyc);
    cyc = 0;
    while (!if0.done && cyc < 40) begin
      if (if0.busy) cyc++;
      @(negedge clk);
    end
  endtask

  task automatic wait_done1(output int cyc);
    cyc = 0;
    while (!if1.done && cyc < 40) begin
      if (if1.busy) cyc++;
      @(negedge clk);
    end
  endtask

  task automatic op0(input logic [31:0] av, input logic [31:0] bv, input logic sm,
                     input logic [63:0] exp, input string nm);
    int cyc;
    launch0(av, bv, sm);
    wait_done0(cyc);
    check({nm, "_busy_cycles"}, 64'(cyc), 64'(LAT0));
    check({nm, "_done"}, 64'(if0.done), 64'd1);
    check({nm, "_product"}, if0.product, exp);
    @(negedge clk);
    check({nm, "_done_pulse"}, 64'(if0.done), 64'd0);
    check({nm, "_product_hold"}, if0.product, exp);
  endtask

  task automatic op1(input logic [15:0] av, input logic [7:0] bv, input string nm);
    int cyc;
    logic [23:0] exp;
    exp = 24'(av) * 24'(bv);
    @(negedge clk);
    if1.start = 1'b1;
    if1.a     = av;
    if1.b     = bv;
    @(negedge clk);
    if1.start = 1'b0;
    wait_done1(cyc);
    check({nm, "_busy_cycles"}, 64'(cyc), 64'(LAT1));
    check({nm, "_product"}, 64'(if1.product), 64'(exp));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    checks = 0;
    errors = 0;

    vecs[0] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001, "max_x_max"};
    vecs[1] = '{32'h0000_0003, 32'h0000_0005, 64'h0000_0000_0000_000F, "3x5"};
    vecs[2] = '{32'h0000_0000, 32'h1234_5678, 64'h0000_0000_0000_0000, "zero_a"};
    vecs[3] = '{32'h0000_0001, 32'hDEAD_BEEF, 64'h0000_0000_DEAD_BEEF, "one_a"};
    vecs[4] = '{32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000, "pow2"};
    vecs[5] = '{32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780, "shift4"};
    vecs[6] = '{32'hFFFF_FFFF, 32'h0000_0002, 64'h0000_0001_FFFF_FFFE, "max_x2"};
    vecs[7] = '{32'h0000_FFFF, 32'h0000_FFFF, 64'h0000_0000_FFFE_0001, "half_sq"};

    if0.start = 1'b0;
    if0.a     = '0;
    if0.b     = '0;
    if1.start = 1'b0;
    if1.a     = '0;
    if1.b     = '0;
`ifdef MULT_SEQ_SIGNED_EN
    if0.signed_mode = 1'b0;
    if1.signed_mode = 1'b0;
`endif

    // Reset for 4 cycles.
    reset = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_busy", 64'(if0.busy), 64'd0);
    check("rst_done", 64'(if0.done), 64'd0);
    check("rst_product", if0.product, 64'd0);
    check("rst_product1", 64'(if1.product), 64'd0);
    reset = 1'b0;

    // Table-driven vectors.
    for (int k = 0; k < 8; k++) begin
      op0(vecs[k].a, vecs[k].b, 1'b0, vecs[k].exp, vecs[k].nm);
    end

    // Back-to-back: second start lands in the done cycle.
    launch0(32'd3, 32'd5, 1'b0);
    wait_done0(cyc);
    check("b2b_first_cycles", 64'(cyc), 64'(LAT0));
    check("b2b_first_product", if0.product, 64'h0000_0000_0000_000F);
    if0.start = 1'b1;
    if0.a     = 32'h8000_0000;
    if0.b     = 32'd2;
    @(negedge clk);
    if0.start = 1'b0;
    check("b2b_busy_no_gap", 64'(if0.busy), 64'd1);
    check("b2b_product_cleared", if0.product, 64'd0);
    check("b2b_done_low", 64'(if0.done), 64'd0);
    wait_done0(cyc);
    check("b2b_second_cycles", 64'(cyc), 64'(LAT0));
    check("b2b_second_product", if0.product, 64'h0000_0001_0000_0000);

    // start while busy, plus operand changes, must be ignored.
    launch0(32'd7, 32'd9, 1'b0);
    check("busy_after_start", 64'(if0.busy), 64'd1);
    if0.start = 1'b1;
    if0.a     = 32'h0000_FFFF;
    if0.b     = 32'h0000_FFFF;
    @(negedge clk);
    if0.start = 1'b0;
    if0.a     = 32'hAAAA_5555;
    if0.b     = 32'h1234_0000;
    wait_done0(cyc);
    check("ignore_start_cycles", 64'(cyc + 1), 64'(LAT0));
    check("ignore_start_product", if0.product, 64'h0000_0000_0000_003F);
    @(negedge clk);
    check("ignore_start_no_extend", 64'(if0.busy), 64'd0);

    // Reset at RUN cycle 4 aborts the operation.
    launch0(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_busy", 64'(if0.busy), 64'd0);
    check("abort_done", 64'(if0.done), 64'd0);
    check("abort_product", if0.product, 64'd0);
    op0(32'h0000_1234, 32'h0000_5678, 1'b0, 64'h0000_0000_0626_0060, "after_abort");

    // Reset wins over start in the same cycle.
    @(negedge clk);
    reset     = 1'b1;
    if0.start = 1'b1;
    if0.a     = 32'd5;
    if0.b     = 32'd5;
    @(negedge clk);
    reset     = 1'b0;
    if0.start = 1'b0;
    check("rst_prio_busy", 64'(if0.busy), 64'd0);
    @(negedge clk);
    check("rst_prio_stays_idle", 64'(if0.busy), 64'd0);

`ifdef MULT_SEQ_SIGNED_EN
    op0(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, "s_m1x1");
    op0(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "s_min_sq");
    op0(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "s_m3x5");
    op0(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 64'h0000_0000_FFFF_FFFF, "u_in_sbuild");
`endif

    // 16x8 configuration with 4x8 slices.
    op1(16'hFFFF, 8'hFF, "p_max");
    op1(16'h0001, 8'h01, "p_one");
    for (int k = 0; k < 10; k++) begin
      op1(16'($urandom), 8'($urandom), $sformatf("p_rand%0d", k));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_seq.md
Name: mult_seq

Overview:
- Parametrised multi-cycle unsigned integer multiplier. It is the next generation of the team's 32x32 sequential multiplier.
- It computes A_WIDTH x B_WIDTH products by iterating one SLICE_A x SLICE_B partial product per cycle and accumulating into a shifted product register.
- It sits behind a start/busy/done handshake and serves datapath blocks that trade latency for area.

Parameters:
- A_WIDTH, 32, operand a width; must be a multiple of SLICE_A.
- B_WIDTH, 32, operand b width; must be a multiple of SLICE_B.
- SLICE_A, 8, a-slice width fed to the slice multiplier per cycle.
- SLICE_B, 16, b-slice width fed to the slice multiplier per cycle.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only while idle.
- a  input  A_WIDTH  multiplicand; captured on accepted start.
- b  input  B_WIDTH  multiplier; captured on accepted start.
- busy  output  1  high while a multiplication is in progress.
- done  output  1  one-cycle pulse when product becomes valid.
- product  output  A_WIDTH+B_WIDTH  result register; holds until the next accepted start.

Behaviour:
- Reset values: busy=0, done=0, product=0, state=IDLE, slice counters=0.
- N = (A_WIDTH/SLICE_A)*(B_WIDTH/SLICE_B). Default N = 4*2 = 8.
- States: IDLE, RUN.
- IDLE: if start=1 at edge E:
  - capture a and b into internal registers;
  - clear product to 0 and zero the counters;
  - go to RUN; busy=1 from E onward.
- IDLE with start=0: hold all registers; done=0.
- RUN, one slice per edge:
  - product += zero-extend(a_slice[i] * b_slice[j]) << (i*SLICE_A + j*SLICE_B);
  - i is the inner index (a slices), j is the outer index (b slices), both LSB-first.
- On the N-th RUN edge (E+N): last accumulate, state→IDLE, busy→0, done→1 for exactly one cycle.
- Latency: start sampled at E → product valid and done=1 after edge E+N; busy high for exactly N cycles.
- start while busy=1 is ignored; no queuing. Operand changes on a/b while busy have no effect.
- start asserted in the done cycle is accepted:
  - product clears at that edge;
  - busy rises immediately, giving back-to-back operation with no idle gap.
- Accumulator width is A_WIDTH+B_WIDTH. Intermediate sums never overflow, so no carry is lost.
- Reset mid-operation aborts the calculation. At the next edge: busy=0, done=0, product=0, state=IDLE.
- reset has priority over start in the same cycle.

Optional Feature:
- Macro: MULT_SEQ_SIGNED_EN.
- Defined:
  - adds port signed_mode (input, 1), captured with the operands on accepted start;
  - when signed_mode=1, operands are treated as two's complement;
  - magnitudes are multiplied unsigned during RUN;
  - an extra state FIX follows RUN and negates product when the sign bits differ;
  - latency is always N+1, independent of signed_mode, and done pulses after FIX.
- Not defined: no signed_mode port, no FIX state, latency N, unsigned only.

Decomposition:
- Shared package mult_seq_pkg:
  - state enum (IDLE, RUN, FIX);
  - function computing counter widths via $clog2 of the slice counts;
  - localparam default widths.
- One natural sub-module, mult_slice:
  - purely combinational SLICE_A x SLICE_B unsigned multiplier, output width SLICE_A+SLICE_B;
  - instantiated once, so it can be swapped for a DSP primitive.

Test Plan:
- Reset for 4 cycles, a=0xFFFFFFFF, b=0xFFFFFFFF, start 1 cycle → busy high 8 cycles, then done pulse, product=0xFFFFFFFE00000001.
- a=3, b=5 → product=0x000000000000000F after 8 cycles; a second start in the done cycle with a=0x80000000, b=2 → product=0x0000000100000000 with no idle gap.
- start pulsed while busy with different operands → ignored; the first result is intact and busy is not extended.
- reset asserted at RUN cycle 4 → next edge busy=0, done=0, product=0; a subsequent start computes correctly.
- Parameter sweep A_WIDTH=16, B_WIDTH=8, SLICE_A=4, SLICE_B=8 (N=4), random operands vs a reference model → busy exactly 4 cycles, all products match.
- MULT_SEQ_SIGNED_EN defined, signed_mode=1:
  - a=0xFFFFFFFF, b=1 → product=0xFFFFFFFFFFFFFFFF;
  - a=b=0x80000000 → product=0x4000000000000000;
  - latency 9.
